// File: rtl/dmac_cfg_pkg.sv
// Shared definitions for the DMA configuration register block:
// register word offsets, STATUS bit positions and the sequencing FSM states.
package dmac_cfg_pkg;

  localparam int unsigned OFS_VERSION = 32'h000;
  localparam int unsigned OFS_SRC     = 32'h100;
  localparam int unsigned OFS_DST     = 32'h104;
  localparam int unsigned OFS_LEN     = 32'h108;
  localparam int unsigned OFS_CMD     = 32'h10C;
  localparam int unsigned OFS_STATUS  = 32'h110;
  localparam int unsigned OFS_INTEN   = 32'h114;

  localparam int unsigned ST_DONE     = 0;
  localparam int unsigned ST_IRQ_PEND = 1;
  localparam int unsigned ST_BUSY_ERR = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/dmac_cfg_apb.sv
// APB register block in front of the DMA engine: holds SRC/DST/LEN, fires a
// one-cycle start pulse, tracks engine busy/done and raises a maskable irq.
//
// state | meaning
// IDLE  | engine idle; config writable, CMD start accepted when LEN != 0
// START | start_o high for this single cycle; engine done not yet valid
// BUSY  | waiting for done_i; config writes rejected with pslverr
module dmac_cfg_apb
  import dmac_cfg_pkg::*;
#(
  parameter logic [31:0] VERSION = 32'h0001_2024,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o,
  output logic [15:0]       byte_len_o,
  output logic              start_o,
  input  logic              done_i,
  output logic              irq_o
);

  cfg_state_t  state_q;
  logic        start_q;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        inten_q, inten_d;
  logic        irq_pend_q, irq_pend_d;
  logic        busy_err_q, busy_err_d;
  logic        irq_q, irq_d;
  logic [31:0] prdata_q, prdata_d;

  logic [ADDR_W-1:0] addr_w;
  logic hit_version, hit_src, hit_dst, hit_len, hit_cmd, hit_status, hit_inten;
  logic mapped, is_idle, setup_rd, access, wr, cfg_blocked, cmd_start, done_evt;
  logic [31:0] status_vec, rd_data;
  logic        unused_addr_lsb;

  assign addr_w          = {paddr_i[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^paddr_i[1:0];

  assign hit_version = (addr_w == ADDR_W'(OFS_VERSION));
  assign hit_src     = (addr_w == ADDR_W'(OFS_SRC));
  assign hit_dst     = (addr_w == ADDR_W'(OFS_DST));
  assign hit_len     = (addr_w == ADDR_W'(OFS_LEN));
  assign hit_cmd     = (addr_w == ADDR_W'(OFS_CMD));
  assign hit_status  = (addr_w == ADDR_W'(OFS_STATUS));
  assign hit_inten   = (addr_w == ADDR_W'(OFS_INTEN));
  assign mapped      = hit_version | hit_src | hit_dst | hit_len |
                       hit_cmd | hit_status | hit_inten;

  assign is_idle     = (state_q == IDLE);
  assign setup_rd    = psel_i & ~penable_i & ~pwrite_i;
  assign access      = psel_i & penable_i;
  assign wr          = access & pwrite_i;
  // Config registers are frozen while the engine owns them.
  assign cfg_blocked = ~is_idle & (hit_src | hit_dst | hit_len);
  assign cmd_start   = wr & hit_cmd & pwdata_i[0];
  assign done_evt    = (state_q == BUSY) & done_i;

  assign pready_o  = 1'b1;
  assign pslverr_o = access & (~mapped | (pwrite_i & cfg_blocked));

  always_comb begin
    status_vec              = '0;
    status_vec[ST_DONE]     = is_idle;
    status_vec[ST_IRQ_PEND] = irq_pend_q;
    status_vec[ST_BUSY_ERR] = busy_err_q;
    rd_data                 = '0;
    if (hit_version)     rd_data = VERSION;
    else if (hit_src)    rd_data = src_q;
    else if (hit_dst)    rd_data = dst_q;
    else if (hit_len)    rd_data = {16'd0, len_q};
    else if (hit_status) rd_data = status_vec;
    else if (hit_inten)  rd_data = {31'd0, inten_q};
  end

  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    inten_d    = inten_q;
    if (wr && is_idle && hit_src) src_d = pwdata_i;
    if (wr && is_idle && hit_dst) dst_d = pwdata_i;
    if (wr && is_idle && hit_len) len_d = pwdata_i[15:0];
    if (wr && hit_inten)          inten_d = pwdata_i[0];
    // Set terms are OR-ed in last so a same-edge set beats a W1C clear.
    irq_pend_d = (irq_pend_q & ~(wr & hit_status & pwdata_i[ST_IRQ_PEND])) | done_evt;
    busy_err_d = (busy_err_q & ~(wr & hit_status & pwdata_i[ST_BUSY_ERR])) |
                 (cmd_start & ~is_idle);
    irq_d      = irq_pend_q & inten_q;
    prdata_d   = setup_rd ? rd_data : prdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      inten_q    <= 1'b0;
      irq_pend_q <= 1'b0;
      busy_err_q <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
    end else begin
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      inten_q    <= inten_d;
      irq_pend_q <= irq_pend_d;
      busy_err_q <= busy_err_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
    end
  end

  // done_i is ignored in START: the engine still reports idle on that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_start && (len_q != 16'd0)) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START:   state_q <= BUSY;
        BUSY:    if (done_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata_o   = prdata_q;
  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;
  assign byte_len_o = len_q;
  assign start_o    = start_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_dmac_cfg_apb.sv
// Bench for dmac_cfg_apb: behavioural register/engine model compared every
// cycle, directed scenarios with literal expectations, then random APB traffic.
module tb_dmac_cfg_apb;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready, pslverr, start, irq;
  logic [31:0] prdata, src_addr, dst_addr;
  logic [15:0] byte_len;
  logic        done_i;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  dmac_cfg_apb dut (
    .clk(clk), .rst(rst),
    .psel_i(psel), .penable_i(penable), .paddr_i(paddr), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
    .src_addr_o(src_addr), .dst_addr_o(dst_addr), .byte_len_o(byte_len),
    .start_o(start), .done_i(done_i), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = idle, 1 = start cycle, 2 = engine running.
  bit [31:0] m_src, m_dst, m_prdata;
  bit [15:0] m_len;
  bit        m_inten, m_pend, m_berr, m_irq, m_start;
  int        m_phase;
  bit        model_on = 1'b0;
  bit [11:0] ma;
  bit        mwr, msetup, mevt, mgo, mclr_pend, mclr_berr;
  int        mnext;

  function automatic bit [31:0] m_read(input bit [11:0] a);
    case ({a[11:2], 2'b00})
      12'h000: return 32'h0001_2024;
      12'h100: return m_src;
      12'h104: return m_dst;
      12'h108: return {16'd0, m_len};
      12'h110: return {29'd0, m_berr, m_pend, m_phase == 0};
      12'h114: return {31'd0, m_inten};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_mapped(input bit [11:0] a);
    bit [11:0] w;
    w = {a[11:2], 2'b00};
    return (w == 12'h000) || (w >= 12'h100 && w <= 12'h114);
  endfunction

  function automatic bit m_is_cfg(input bit [11:0] a);
    bit [11:0] w;
    w = {a[11:2], 2'b00};
    return (w == 12'h100) || (w == 12'h104) || (w == 12'h108);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_src = 0; m_dst = 0; m_len = 0; m_inten = 0; m_pend = 0; m_berr = 0;
      m_irq = 0; m_start = 0; m_phase = 0; m_prdata = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      ma        = {paddr[11:2], 2'b00};
      mwr       = psel && penable && pwrite;
      msetup    = psel && !penable && !pwrite;
      mevt      = (m_phase == 2) && done_i;
      mgo       = mwr && ma == 12'h10C && pwdata[0];
      mclr_pend = mwr && ma == 12'h110 && pwdata[1];
      mclr_berr = mwr && ma == 12'h110 && pwdata[2];
      if (msetup) m_prdata = m_read(paddr);
      m_irq  = m_pend && m_inten;
      m_berr = (mgo && m_phase != 0) || (m_berr && !mclr_berr);
      m_pend = mevt || (m_pend && !mclr_pend);
      mnext  = m_phase;
      if (m_phase == 0 && mgo && m_len != 0) mnext = 1;
      else if (m_phase == 1) mnext = 2;
      else if (mevt) mnext = 0;
      if (mwr && m_phase == 0) begin
        if (ma == 12'h100) m_src = pwdata;
        if (ma == 12'h104) m_dst = pwdata;
        if (ma == 12'h108) m_len = pwdata[15:0];
      end
      if (mwr && ma == 12'h114) m_inten = pwdata[0];
      m_phase = mnext;
      m_start = (mnext == 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (model_on) begin
      chk("pready", {31'd0, pready}, 32'd1);
      chk("prdata", prdata, m_prdata);
      chk("pslverr", {31'd0, pslverr},
          {31'd0, psel && penable &&
                  (!m_mapped(paddr) || (pwrite && m_is_cfg(paddr) && m_phase != 0))});
      chk("src_addr", src_addr, m_src);
      chk("dst_addr", dst_addr, m_dst);
      chk("byte_len", {16'd0, byte_len}, {16'd0, m_len});
      chk("start", {31'd0, start}, {31'd0, m_start});
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic apb_write(input bit [11:0] a, input bit [31:0] d, input bit raise_done,
                           output bit err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    if (raise_done) done_i = 1;
    @(negedge clk) err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input bit [11:0] a, output bit [31:0] d, output bit err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    d = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  bit [31:0] rd;
  bit        er;
  int        cnt0;
  bit [11:0] addr_pool [10] = '{12'h000, 12'h100, 12'h104, 12'h108, 12'h10C,
                                12'h110, 12'h114, 12'h200, 12'hFFC, 12'h118};

  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; done_i = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    apb_read(12'h000, rd, er); chk("version", rd, 32'h0001_2024);
    apb_read(12'h110, rd, er); chk("status_reset", rd, 32'h1);
    chk("irq_reset", {31'd0, irq}, 32'd0);

    apb_write(12'h100, 32'h1000, 0, er);
    apb_write(12'h104, 32'h2000, 0, er);
    apb_write(12'h108, 32'h40, 0, er);
    apb_write(12'h114, 32'h1, 0, er);
    apb_write(12'h10C, 32'h1, 0, er);
    @(negedge clk) chk("start_pulse_hi", {31'd0, start}, 32'd1);
    @(posedge clk); #1 done_i = 0;
    @(negedge clk) chk("start_pulse_lo", {31'd0, start}, 32'd0);
    apb_read(12'h110, rd, er); chk("status_busy", rd, 32'h0);
    repeat (15) @(posedge clk);
    #1 done_i = 1;
    @(negedge clk);
    @(negedge clk) chk("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk) chk("irq_rise", {31'd0, irq}, 32'd1);
    apb_read(12'h110, rd, er); chk("status_done", rd, 32'h3);

    apb_write(12'h110, 32'h2, 0, er);
    @(negedge clk) chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk) chk("irq_fall", {31'd0, irq}, 32'd0);
    apb_read(12'h110, rd, er); chk("status_cleared", rd, 32'h1);

    apb_write(12'h10C, 32'h1, 0, er);
    @(posedge clk); #1 done_i = 0;
    apb_write(12'h110, 32'h2, 1, er);
    apb_read(12'h110, rd, er); chk("set_beats_clear", rd, 32'h3);
    apb_write(12'h110, 32'h2, 0, er);

    apb_write(12'h10C, 32'h1, 0, er);
    @(posedge clk); #1 done_i = 0;
    apb_write(12'h108, 32'h80, 0, er); chk("len_busy_err", {31'd0, er}, 32'd1);
    apb_read(12'h108, rd, er); chk("len_kept", rd, 32'h40);
    cnt0 = start_cnt;
    apb_write(12'h10C, 32'h1, 0, er); chk("cmd_busy_noerr", {31'd0, er}, 32'd0);
    repeat (3) @(negedge clk);
    chk("cmd_busy_nostart", start_cnt, cnt0);
    apb_read(12'h110, rd, er); chk("status_busy_err", rd, 32'h4);
    done_i = 1;
    repeat (3) @(posedge clk);
    apb_write(12'h110, 32'h6, 0, er);
    apb_read(12'h110, rd, er); chk("status_idle", rd, 32'h1);

    apb_write(12'h108, 32'h0, 0, er);
    cnt0 = start_cnt;
    apb_write(12'h10C, 32'h1, 0, er);
    repeat (3) @(negedge clk);
    chk("len0_nostart", start_cnt, cnt0);
    apb_read(12'h110, rd, er); chk("len0_idle", rd, 32'h1);
    apb_read(12'h200, rd, er);
    chk("unmapped_data", rd, 32'h0);
    chk("unmapped_err", {31'd0, er}, 32'd1);

    apb_write(12'h108, 32'h10, 0, er);
    apb_write(12'h10C, 32'h1, 0, er);
    @(posedge clk); #1 done_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0; done_i = 1;
    @(negedge clk);
    chk("rst_src", src_addr, 32'h0);
    chk("rst_dst", dst_addr, 32'h0);
    chk("rst_len", {16'd0, byte_len}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    apb_read(12'h110, rd, er); chk("rst_status", rd, 32'h1);

    for (int i = 0; i < 400; i++) begin
      bit [11:0] a;
      bit [31:0] d;
      a = addr_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) a = a | 12'($urandom_range(1, 3));
      d = $urandom;
      if (a[11:2] == 10'h042 && $urandom_range(0, 3) == 0) d = 32'h0;
      if (a[11:2] == 10'h042) d = d & 32'h0000_00FF;
      done_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) apb_write(a, d, 0, er);
      else apb_read(a, rd, er);
      if ($urandom_range(0, 149) == 0) begin
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
